// File: rtl/word_flip_memory_if.sv
// -----------------------------------------------------------------------------
// word_flip_memory_if
// Bundles the write/modify port and the registered read port of
// word_flip_memory so the datapath side and the memory side share one
// declaration of widths and directions.
//
// Parameters:
//   WIDTH - bits per stored word
//   DEPTH - number of entries (need not be a power of two)
//
// Signals:
//   op         : write operation, 00 NOP / 01 STORE / 10 FLIP / 11 CLEAR
//   wr_addr    : target entry of the write/modify operation
//   wr_data    : STORE value or FLIP mask
//   rd_en      : read request
//   rd_addr    : entry to read
//   rd_data    : registered read result
//   rd_valid   : read result valid (one cycle after an accepted rd_en)
//   rd_written : entry read had been STOREd/FLIPped since reset or last CLEAR
//   err        : one-cycle pulse for an out-of-range write and/or read
//
// Modports:
//   master - the datapath driving requests
//   slave  - the memory answering them
// -----------------------------------------------------------------------------
interface word_flip_memory_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]       op;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_written;
    logic             err;

    modport master (
        output op, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, rd_written, err
    );

    modport slave (
        input  op, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, rd_written, err
    );
endinterface

// File: rtl/word_flip_memory.sv
// -----------------------------------------------------------------------------
// word_flip_memory
// DEPTH-entry array of WIDTH-bit words with an edge-triggered write port
// (STORE, FLIP by XOR mask, CLEAR), per-entry "written" tracking and a
// registered read port with one cycle of latency. Addresses at or above
// DEPTH are rejected: writes are ignored, reads return zero, and err pulses.
//
// Parameters:
//   WIDTH - bits per word (>= 1)
//   DEPTH - number of entries (>= 1, any value)
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears array, written bits and outputs
//   bus   - word_flip_memory_if.slave carrying the write and read ports
//
// Build option:
//   WFM_WRITE_FORWARD_EN - when defined, a read that hits the entry being
//   written in the same cycle returns the post-operation value and written
//   bit; when undefined the read returns the pre-operation contents.
// -----------------------------------------------------------------------------
module word_flip_memory #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    word_flip_memory_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_STORE = 2'b01,
        OP_FLIP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;

    logic [WIDTH-1:0] rdData_q, rdData_d;
    logic             rdValid_q, rdValid_d;
    logic             rdWritten_q, rdWritten_d;
    logic             err_q, err_d;

    logic             wrInRange, rdInRange, wrActive;
    logic [WIDTH-1:0] wrOld, wrNew;
    logic             wrOldWritten, wrNewWritten;

    // Work out what the addressed entry becomes under the requested
    // operation. Out-of-range addresses are masked to zero so the array is
    // never indexed past its end; wrActive then keeps them from committing.
    always_comb begin
        wrInRange    = ({1'b0, bus.wr_addr} < DEPTH_W);
        rdInRange    = ({1'b0, bus.rd_addr} < DEPTH_W);
        wrActive     = (op_e'(bus.op) != OP_NOP) && wrInRange;
        wrOld        = wrInRange ? mem_q[bus.wr_addr] : '0;
        wrOldWritten = wrInRange ? written_q[bus.wr_addr] : 1'b0;
        wrNew        = wrOld;
        wrNewWritten = wrOldWritten;
        case (op_e'(bus.op))
            OP_STORE: begin
                wrNew        = bus.wr_data;
                wrNewWritten = 1'b1;
            end
            OP_FLIP: begin
                wrNew        = wrOld ^ bus.wr_data;
                wrNewWritten = 1'b1;
            end
            OP_CLEAR: begin
                wrNew        = '0;
                wrNewWritten = 1'b0;
            end
            default: begin
                wrNew        = wrOld;
                wrNewWritten = wrOldWritten;
            end
        endcase
    end

    // Next state of the array: only the addressed entry may change, and only
    // when the operation is real and the address exists.
    always_comb begin
        mem_d     = mem_q;
        written_d = written_q;
        if (wrActive) begin
            mem_d[bus.wr_addr]     = wrNew;
            written_d[bus.wr_addr] = wrNewWritten;
        end
    end

    // Read port and error flag. Without a read request the data and written
    // outputs hold; only rd_valid drops. A write error and a read error in
    // the same cycle merge into one err pulse.
    always_comb begin
        rdData_d    = rdData_q;
        rdWritten_d = rdWritten_q;
        rdValid_d   = bus.rd_en;
        err_d       = ((op_e'(bus.op) != OP_NOP) && !wrInRange) ||
                      (bus.rd_en && !rdInRange);
        if (bus.rd_en) begin
            if (!rdInRange) begin
                rdData_d    = '0;
                rdWritten_d = 1'b0;
            end else begin
`ifdef WFM_WRITE_FORWARD_EN
                if (wrActive && (bus.wr_addr == bus.rd_addr)) begin
                    rdData_d    = wrNew;
                    rdWritten_d = wrNewWritten;
                end else begin
                    rdData_d    = mem_q[bus.rd_addr];
                    rdWritten_d = written_q[bus.rd_addr];
                end
`else
                rdData_d    = mem_q[bus.rd_addr];
                rdWritten_d = written_q[bus.rd_addr];
`endif
            end
        end
    end

    // State registers. Reset wins over any operation or read in its cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q       <= '{default: '0};
            written_q   <= '0;
            rdData_q    <= '0;
            rdValid_q   <= 1'b0;
            rdWritten_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            written_q   <= written_d;
            rdData_q    <= rdData_d;
            rdValid_q   <= rdValid_d;
            rdWritten_q <= rdWritten_d;
            err_q       <= err_d;
        end
    end

    assign bus.rd_data    = rdData_q;
    assign bus.rd_valid   = rdValid_q;
    assign bus.rd_written = rdWritten_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_word_flip_memory.sv
// -----------------------------------------------------------------------------
// tb_word_flip_memory
// Directed bench for word_flip_memory built with DEPTH=5 so that addresses
// 5..7 exist on the 3-bit bus and exercise the out-of-range path. A small
// reference model of the array predicts each cycle's outputs; predictions
// are queued when a step is driven and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_word_flip_memory;
    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int AW    = 3;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] STORE = 2'b01;
    localparam logic [1:0] FLIP  = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             written;
        logic             err;
    } exp_t;

    logic clk;
    logic reset;

    word_flip_memory_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    word_flip_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [WIDTH-1:0] modelMem [DEPTH];
    logic             modelWritten [DEPTH];
    logic [WIDTH-1:0] lastData;
    logic             lastWritten;
    exp_t             scoreboard [$];
    int               evaluated;
    int               failures;
    int               stepNo;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counted, then asserted.
    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        evaluated++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s step%0d observed=%0h expected=%0h",
                   tag, stepNo, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus, predict the outputs it should produce from
    // the model, queue that prediction, then advance past the clock edge.
    task automatic applyStimulus(input logic rst, input logic [1:0] op,
                                 input int waddr, input logic [WIDTH-1:0] wdata,
                                 input logic rden, input int raddr);
        exp_t             e;
        logic             wrOk;
        logic [WIDTH-1:0] newVal;
        logic             newWritten;
        logic [AW-1:0]    wa;
        logic [AW-1:0]    ra;
        wa = waddr[AW-1:0];
        ra = raddr[AW-1:0];
        reset       = rst;
        bus.op      = op;
        bus.wr_addr = wa;
        bus.wr_data = wdata;
        bus.rd_en   = rden;
        bus.rd_addr = ra;
        e = '0;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                modelMem[i]     = '0;
                modelWritten[i] = 1'b0;
            end
            lastData    = '0;
            lastWritten = 1'b0;
        end else begin
            wrOk       = (op != NOP) && (waddr < DEPTH);
            newVal     = '0;
            newWritten = 1'b0;
            if (wrOk) begin
                if (op == STORE) begin
                    newVal     = wdata;
                    newWritten = 1'b1;
                end else if (op == FLIP) begin
                    newVal     = modelMem[waddr] ^ wdata;
                    newWritten = 1'b1;
                end
            end
            e.err   = ((op != NOP) && (waddr >= DEPTH)) ||
                      (rden && (raddr >= DEPTH));
            e.valid = rden;
            if (rden) begin
                if (raddr >= DEPTH) begin
                    lastData    = '0;
                    lastWritten = 1'b0;
                end else begin
                    lastData    = modelMem[raddr];
                    lastWritten = modelWritten[raddr];
`ifdef WFM_WRITE_FORWARD_EN
                    if (wrOk && (waddr == raddr)) begin
                        lastData    = newVal;
                        lastWritten = newWritten;
                    end
`endif
                end
            end
            e.data    = lastData;
            e.written = lastWritten;
            if (wrOk) begin
                modelMem[waddr]     = newVal;
                modelWritten[waddr] = newWritten;
            end
        end
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Pop the prediction for the cycle just clocked and compare all outputs.
    task automatic checkOutput();
        exp_t e;
        stepNo++;
        if (scoreboard.size() == 0) begin
            evaluated++;
            failures++;
            $error("[TB] FAIL scoreboard_empty step%0d observed=0 expected=1", stepNo);
        end else begin
            e = scoreboard.pop_front();
            checkValue("rd_valid",   32'(bus.rd_valid),   32'(e.valid));
            checkValue("rd_data",    32'(bus.rd_data),    32'(e.data));
            checkValue("rd_written", 32'(bus.rd_written), 32'(e.written));
            checkValue("err",        32'(bus.err),        32'(e.err));
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] op, input int waddr,
                        input logic [WIDTH-1:0] wdata, input logic rden,
                        input int raddr);
        applyStimulus(rst, op, waddr, wdata, rden, raddr);
        checkOutput();
    endtask

    // Directed sequence following the feature list of the memory.
    initial begin
        evaluated = 0;
        failures  = 0;
        stepNo    = 0;
        reset       = 1'b1;
        bus.op      = NOP;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        @(negedge clk);

        // Reset and read every entry back as zero / not written.
        step(1'b1, NOP, 0, 8'h00, 1'b0, 0);
        step(1'b1, STORE, 1, 8'hEE, 1'b1, 1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, NOP, 0, 8'h00, 1'b1, i);

        // STORE, FLIP, read, FLIP again restores the original value.
        step(1'b0, STORE, 3, 8'h42, 1'b0, 0);
        step(1'b0, STORE, 1, 8'hA5, 1'b0, 0);
        step(1'b0, FLIP,  1, 8'hFF, 1'b0, 0);
        step(1'b0, NOP,   0, 8'h00, 1'b1, 1);
        step(1'b0, FLIP,  1, 8'hFF, 1'b0, 0);
        step(1'b0, NOP,   0, 8'h00, 1'b1, 1);
        step(1'b0, NOP,   0, 8'h00, 1'b0, 0);

        // STORE then CLEAR entry 2; entry 3 keeps its value.
        step(1'b0, STORE, 2, 8'h3C, 1'b0, 0);
        step(1'b0, CLEAR, 2, 8'h99, 1'b0, 0);
        step(1'b0, NOP,   0, 8'h00, 1'b1, 2);
        step(1'b0, NOP,   0, 8'h00, 1'b1, 3);

        // A zero FLIP mask still marks the entry written.
        step(1'b0, FLIP,  4, 8'h00, 1'b1, 4);
        step(1'b0, NOP,   0, 8'h00, 1'b1, 4);

        // Same-cycle write and read of one entry.
        step(1'b0, STORE, 0, 8'h11, 1'b0, 0);
        step(1'b0, STORE, 0, 8'h77, 1'b1, 0);
        step(1'b0, NOP,   0, 8'h00, 1'b1, 0);
        step(1'b0, CLEAR, 0, 8'h00, 1'b1, 0);

        // Read and write to different entries in one cycle.
        step(1'b0, FLIP,  2, 8'h0F, 1'b1, 1);

        // Out of range: write @6 and read @7 give one err pulse.
        step(1'b0, STORE, 6, 8'hC3, 1'b1, 7);
        step(1'b0, NOP,   0, 8'h00, 1'b0, 0);
        step(1'b0, STORE, 5, 8'h5A, 1'b0, 0);
        step(1'b0, NOP,   0, 8'h00, 1'b1, 6);
        for (int i = 0; i < DEPTH; i++) step(1'b0, NOP, 0, 8'h00, 1'b1, i);

        // Reset in the same cycle as a read drops the read.
        step(1'b0, STORE, 3, 8'hFF, 1'b0, 0);
        step(1'b1, NOP,   0, 8'h00, 1'b1, 3);
        step(1'b0, NOP,   0, 8'h00, 1'b1, 3);
        step(1'b0, STORE, 3, 8'h81, 1'b1, 3);
        step(1'b0, NOP,   0, 8'h00, 1'b1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 evaluated, failures);
        $finish;
    end
endmodule
